// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter that shares the single afifo write port among NUM_REQ
// streaming requesters. The owner keeps the grant for a burst, and wr_full back-pressures the owner.
module afifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATASIZE     = 32,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATASIZE-1:0]   req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr,
  output logic [DATASIZE-1:0]           wr_data,
  input  logic                          wr_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  localparam logic [GW-1:0] PTR_INIT  = GW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic          state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rrPtr_q, rrPtr_d;
  logic [BW-1:0] beatCnt_q, beatCnt_d;
  logic [IW-1:0] idleCnt_q, idleCnt_d;

  logic                ownValid;
  logic                ownLast;
  logic [DATASIZE-1:0] ownData;

  logic          hiFound, loFound;
  logic [GW-1:0] hiIdx, loIdx, pickIdx;
  logic          releaseGrant;

  always_comb begin
    ownValid = 1'b0;
    ownLast  = 1'b0;
    ownData  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        ownValid = req_valid[i];
        ownLast  = req_last[i];
        ownData  = req_data[i*DATASIZE +: DATASIZE];
      end
    end
  end

  // Rotating priority: indices above rrPtr win first (lowest such), then the
  // wrapped region from 0 up to and including rrPtr itself.
  always_comb begin
    hiFound = 1'b0;
    loFound = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (GW'(i) > rrPtr_q) begin
          hiFound = 1'b1;
          hiIdx   = GW'(i);
        end else begin
          loFound = 1'b1;
          loIdx   = GW'(i);
        end
      end
    end
    pickIdx = hiFound ? hiIdx : loIdx;
  end

  always_comb begin
    req_ready = '0;
    wr        = 1'b0;
    wr_data   = '0;
    if (state_q == ST_BURST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == GW'(i)) begin
          req_ready[i] = !wr_full;
        end
      end
      wr = ownValid & !wr_full;
      if (wr) begin
        wr_data = ownData;
      end
    end
  end

  // A full FIFO freezes both counters, so a stall never counts toward the idle timeout.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rrPtr_d      = rrPtr_q;
    beatCnt_d    = beatCnt_q;
    idleCnt_d    = idleCnt_q;
    releaseGrant = 1'b0;
    if (state_q == ST_IDLE) begin
      if (|req_valid) begin
        grant_d   = pickIdx;
        state_d   = ST_BURST;
        beatCnt_d = '0;
        idleCnt_d = '0;
      end
    end else if (!wr_full) begin
      if (ownValid) begin
        beatCnt_d = beatCnt_q + 1'b1;
        idleCnt_d = '0;
        if (ownLast || (beatCnt_q == BEAT_LAST)) begin
          releaseGrant = 1'b1;
        end
      end else begin
        idleCnt_d = idleCnt_q + 1'b1;
        if (idleCnt_q == IDLE_LAST) begin
          releaseGrant = 1'b1;
        end
      end
      if (releaseGrant) begin
        rrPtr_d = grant_q;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rrPtr_q   <= PTR_INIT;
      beatCnt_q <= '0;
      idleCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rrPtr_q   <= rrPtr_d;
      beatCnt_q <= beatCnt_d;
      idleCnt_q <= idleCnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ST_BURST);

endmodule
